// File: rtl/bht_counter_table_if.sv
// Fetch/execute-side signal bundle for the branch history table.
// The master drives read, update and flush requests; the slave returns the prediction.
interface bht_counter_table_if #(
  parameter int INDEX_W = 5,
  parameter int CTR_W   = 2
);
  logic               en;
  logic [INDEX_W-1:0] rd_idx;
  logic               upd_valid;
  logic [INDEX_W-1:0] upd_idx;
  logic               upd_taken;
  logic               flush;
  logic               prediction;
  logic [CTR_W-1:0]   pred_ctr;
  logic               busy;

  modport master (
    output en, rd_idx, upd_valid, upd_idx, upd_taken, flush,
    input  prediction, pred_ctr, busy
  );

  modport slave (
    input  en, rd_idx, upd_valid, upd_idx, upd_taken, flush,
    output prediction, pred_ctr, busy
  );
endinterface

// File: rtl/bht_counter_table.sv
// Branch history table of saturating counters with registered prediction and a
// one-entry-per-cycle flush sweep.
//
// state | meaning
// IDLE  | normal operation: reads and training updates accepted
// CLEAR | sweeping ptr over the table writing INIT_CTR; reads give 0, updates dropped
module bht_counter_table #(
  parameter int INDEX_W  = 5,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1
) (
  input logic                clk,
  input logic                arst_n,
  bht_counter_table_if.slave bus
);
  localparam int N = 2 ** INDEX_W;
  localparam logic [CTR_W-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]   INIT_VAL = CTR_W'(INIT_CTR);
  localparam logic [INDEX_W-1:0] PTR_LAST = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state;
  logic [INDEX_W-1:0] ptr;
  logic [CTR_W-1:0]   ctr [N];
  logic [CTR_W-1:0]   upd_next;
  logic [CTR_W-1:0]   rd_val;

  always_comb begin
    upd_next = ctr[bus.upd_idx];
    if (bus.upd_taken) begin
      if (upd_next != CTR_MAX) upd_next = upd_next + 1'b1;
    end else begin
      if (upd_next != '0) upd_next = upd_next - 1'b1;
    end
  end

  // Write-first: a read hitting the entry being trained sees the trained value.
  always_comb begin
    rd_val = ctr[bus.rd_idx];
    if (bus.upd_valid && (bus.upd_idx == bus.rd_idx)) rd_val = upd_next;
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < N; i++) ctr[i] <= INIT_VAL;
      state          <= IDLE;
      ptr            <= '0;
      bus.busy       <= 1'b0;
      bus.prediction <= 1'b0;
      bus.pred_ctr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush) begin
            state          <= CLEAR;
            ptr            <= '0;
            bus.busy       <= 1'b1;
            bus.prediction <= 1'b0;
            bus.pred_ctr   <= '0;
          end else begin
            if (bus.upd_valid) ctr[bus.upd_idx] <= upd_next;
            if (bus.en) begin
              bus.pred_ctr   <= rd_val;
              bus.prediction <= rd_val[CTR_W-1];
            end
          end
        end
        CLEAR: begin
          ctr[ptr]       <= INIT_VAL;
          bus.prediction <= 1'b0;
          bus.pred_ctr   <= '0;
          if (bus.flush) begin
            ptr <= '0;
          end else if (ptr == PTR_LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bht_counter_table.sv
// Directed checks of read latency, training saturation, bypass, flush sweep and reset.
module tb_bht_counter_table;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cnt;

  always #5 clk = ~clk;

  bht_counter_table_if #(.INDEX_W(5), .CTR_W(2)) bus ();

  bht_counter_table #(.INDEX_W(5), .CTR_W(2), .INIT_CTR(1)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [4:0] idx, input logic taken, input int times);
    bus.en = 1'b0;
    bus.upd_valid = 1'b1;
    bus.upd_idx = idx;
    bus.upd_taken = taken;
    repeat (times) cyc();
    bus.upd_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] idx);
    bus.upd_valid = 1'b0;
    bus.en = 1'b1;
    bus.rd_idx = idx;
    cyc();
    bus.en = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.rd_idx = '0; bus.upd_valid = 1'b0; bus.upd_idx = '0;
    bus.upd_taken = 1'b0; bus.flush = 1'b0;
    cyc(); cyc();
    chk("reset_pred", 8'(bus.prediction), 8'd0);
    chk("reset_ctr", 8'(bus.pred_ctr), 8'd0);
    chk("reset_busy", 8'(bus.busy), 8'd0);
    arst_n = 1'b1;

    rd(5'd7);
    chk("rd7_ctr", 8'(bus.pred_ctr), 8'd1);
    chk("rd7_pred", 8'(bus.prediction), 8'd0);
    bus.rd_idx = 5'd9;
    cyc();
    chk("hold_ctr", 8'(bus.pred_ctr), 8'd1);

    upd(5'd3, 1'b1, 3);
    rd(5'd3);
    chk("sat3_ctr", 8'(bus.pred_ctr), 8'd3);
    chk("sat3_pred", 8'(bus.prediction), 8'd1);
    upd(5'd3, 1'b1, 1);
    rd(5'd3);
    chk("sat3_hold", 8'(bus.pred_ctr), 8'd3);

    bus.en = 1'b1; bus.rd_idx = 5'd5;
    bus.upd_valid = 1'b1; bus.upd_idx = 5'd5; bus.upd_taken = 1'b1;
    cyc();
    chk("bypass_ctr", 8'(bus.pred_ctr), 8'd2);
    chk("bypass_pred", 8'(bus.prediction), 8'd1);

    bus.rd_idx = 5'd6; bus.upd_idx = 5'd8; bus.upd_taken = 1'b0;
    cyc();
    chk("indep_rd6", 8'(bus.pred_ctr), 8'd1);
    rd(5'd8);
    chk("indep_rd8", 8'(bus.pred_ctr), 8'd0);

    upd(5'd0, 1'b0, 4);
    rd(5'd0);
    chk("floor0_ctr", 8'(bus.pred_ctr), 8'd0);
    chk("floor0_pred", 8'(bus.prediction), 8'd0);

    // Flush with updates to entry 0 hammered throughout the sweep.
    upd(5'd31, 1'b1, 2);
    rd(5'd31);
    chk("train31", 8'(bus.pred_ctr), 8'd3);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.en = 1'b1; bus.rd_idx = 5'd31;
    bus.upd_valid = 1'b1; bus.upd_idx = 5'd0; bus.upd_taken = 1'b1;
    chk("flush_busy", 8'(bus.busy), 8'd1);
    chk("flush_pred0", 8'(bus.pred_ctr), 8'd0);
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (!bus.busy) break;
      cnt++;
    end
    chk("flush_len", 8'(cnt), 8'd32);
    rd(5'd31);
    chk("flush_rd31", 8'(bus.pred_ctr), 8'd1);
    rd(5'd0);
    chk("flush_drop0", 8'(bus.pred_ctr), 8'd1);

    bus.flush = 1'b1;
    cyc();
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      bus.flush = (cnt == 10);
      cyc();
      if (!bus.busy) break;
      cnt++;
    end
    bus.flush = 1'b0;
    chk("reflush_len", 8'(cnt), 8'd42);

    upd(5'd4, 1'b1, 2);
    upd(5'd31, 1'b0, 1);
    rd(5'd4);
    chk("pre_rst4", 8'(bus.pred_ctr), 8'd3);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    repeat (5) cyc();
    arst_n = 1'b0;
    cyc();
    chk("midrst_busy", 8'(bus.busy), 8'd0);
    arst_n = 1'b1;
    rd(5'd4);
    chk("midrst_rd4", 8'(bus.pred_ctr), 8'd1);
    rd(5'd31);
    chk("midrst_rd31", 8'(bus.pred_ctr), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
